// File: rtl/matmul_pe_scheduler.sv
// matmul_pe_scheduler
//   Hands the n*n output elements (i,j) of one matrix product to an array of
//   m processing elements. It issues at most one job per cycle, to the first
//   idle and enabled PE found by a round-robin scan. It tracks which PEs are
//   busy, counts completions, and pulses done once every job has retired.
//
// Ports
//   clk           clock; all logic is rising-edge
//   rst           synchronous, active-high reset
//   start         begin a product (sampled only while idle)
//   pe_en[m]      per-PE enable; disabled PEs get no new jobs
//   cmp_valid[m]  per-PE completion pulse, one cycle per finished job
//   job_valid     a job is issued this cycle
//   job_pe        target PE of the issued job
//   job_i, job_j  output row / column of the issued job
//   busy          product in progress (ISSUE or DRAIN)
//   done          one-cycle pulse when the product is complete
//   err_spurious  sticky; completion seen from a PE that was not busy
//   perf_cycles   (only with SCHED_PERF_CNT_EN) saturating count of busy cycles
//
// Build option
//   SCHED_PERF_CNT_EN  adds the perf_cycles output and its counter.
//
// state | meaning
// ------+------------------------------------------------------------
// IDLE  | waiting for start; counters hold results of the last product
// ISSUE | handing out (i,j) jobs, one per cycle when a PE is eligible
// DRAIN | all jobs issued; waiting for the outstanding completions
module matmul_pe_scheduler #(
  parameter int n  = 10,
  parameter int m  = 4,
  parameter int IW = (n > 1) ? $clog2(n) : 1,
  parameter int PW = (m > 1) ? $clog2(m) : 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [m-1:0]  pe_en,
  input  logic [m-1:0]  cmp_valid,
  output logic          job_valid,
  output logic [PW-1:0] job_pe,
  output logic [IW-1:0] job_i,
  output logic [IW-1:0] job_j,
  output logic          busy,
  output logic          done,
  output logic          err_spurious
`ifdef SCHED_PERF_CNT_EN
  ,
  output logic [31:0]   perf_cycles
`endif
);

  localparam int TOTAL = n * n;
  localparam int CW    = $clog2(TOTAL + 1);

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN} state_t;

  state_t        state;
  logic [m-1:0]  busy_mask;
  logic [PW-1:0] rr_ptr;
  logic [IW-1:0] issue_i;
  logic [IW-1:0] issue_j;
  logic [CW-1:0] issued_cnt;
  logic [CW-1:0] done_cnt;

  logic [m-1:0]  eligible;
  logic [m-1:0]  comp;
  logic [m-1:0]  grant_onehot;
  logic          grant_found;
  logic [PW-1:0] grant_pe;
  logic [PW-1:0] rr_next;
  logic [CW-1:0] comp_cnt;
  logic [CW-1:0] done_cnt_next;
  logic          spurious_hit;

  // Eligibility uses the registered busy mask, so a PE that completes this
  // cycle only becomes a candidate next cycle.
  assign eligible     = pe_en & ~busy_mask;
  assign comp         = cmp_valid & busy_mask;
  assign spurious_hit = |(cmp_valid & ~busy_mask);

  always_comb begin : grant_scan
    int idx;
    grant_found = 1'b0;
    grant_pe    = '0;
    idx         = 0;
    for (int k = 0; k < m; k++) begin
      idx = (int'(rr_ptr) + k) % m;
      if (!grant_found && eligible[PW'(idx)]) begin
        grant_found = 1'b1;
        grant_pe    = PW'(idx);
      end
    end
  end

  always_comb begin
    grant_onehot           = '0;
    grant_onehot[grant_pe] = 1'b1;
  end

  assign rr_next = (grant_pe == PW'(m - 1)) ? '0 : grant_pe + PW'(1);

  always_comb begin
    comp_cnt = '0;
    for (int k = 0; k < m; k++) comp_cnt = comp_cnt + CW'(comp[k]);
  end

  assign done_cnt_next = done_cnt + comp_cnt;

  assign job_valid = (state == ISSUE) && grant_found;
  assign job_pe    = job_valid ? grant_pe : '0;
  assign job_i     = issue_i;
  assign job_j     = issue_j;
  assign busy      = (state != IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      busy_mask    <= '0;
      rr_ptr       <= '0;
      issue_i      <= '0;
      issue_j      <= '0;
      issued_cnt   <= '0;
      done_cnt     <= '0;
      done         <= 1'b0;
      err_spurious <= 1'b0;
`ifdef SCHED_PERF_CNT_EN
      perf_cycles  <= '0;
`endif
    end else begin
      done      <= 1'b0;
      busy_mask <= busy_mask & ~comp;
      done_cnt  <= done_cnt_next;
      if (spurious_hit) err_spurious <= 1'b1;
`ifdef SCHED_PERF_CNT_EN
      if (state != IDLE && perf_cycles != 32'hFFFF_FFFF)
        perf_cycles <= perf_cycles + 32'd1;
`endif
      case (state)
        IDLE: begin
          if (start) begin
            state        <= ISSUE;
            busy_mask    <= '0;
            issue_i      <= '0;
            issue_j      <= '0;
            issued_cnt   <= '0;
            done_cnt     <= '0;
            err_spurious <= 1'b0;
`ifdef SCHED_PERF_CNT_EN
            perf_cycles  <= '0;
`endif
          end
        end
        ISSUE: begin
          if (job_valid) begin
            // Issue and completion never target the same PE: a busy PE is
            // never eligible, and only busy PEs can complete.
            busy_mask  <= (busy_mask & ~comp) | grant_onehot;
            rr_ptr     <= rr_next;
            issued_cnt <= issued_cnt + CW'(1);
            if (issue_j == IW'(n - 1)) begin
              issue_j <= '0;
              issue_i <= issue_i + IW'(1);
            end else begin
              issue_j <= issue_j + IW'(1);
            end
            if (issued_cnt == CW'(TOTAL - 1)) state <= DRAIN;
          end
        end
        DRAIN: begin
          if (done_cnt_next == CW'(TOTAL)) begin
            state <= IDLE;
            done  <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_matmul_pe_scheduler.sv
module tb_matmul_pe_scheduler;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic       rst;
  logic       start_a, start_b;
  logic [3:0] pe_en_a, pe_en_b;
  logic [3:0] cmp_a, cmp_b;
  logic       job_valid_a, job_valid_b;
  logic [1:0] job_pe_a, job_pe_b;
  logic       job_i_a, job_j_a;
  logic [1:0] job_i_b, job_j_b;
  logic       busy_a, busy_b, done_a, done_b, err_a, err_b;
`ifdef SCHED_PERF_CNT_EN
  logic [31:0] perf_a, perf_b;
`endif

  // A: n=2, m=4.  B: n=3, m=4.
  matmul_pe_scheduler #(.n(2), .m(4)) u_a (
    .clk(clk), .rst(rst), .start(start_a), .pe_en(pe_en_a), .cmp_valid(cmp_a),
    .job_valid(job_valid_a), .job_pe(job_pe_a), .job_i(job_i_a), .job_j(job_j_a),
    .busy(busy_a), .done(done_a), .err_spurious(err_a)
`ifdef SCHED_PERF_CNT_EN
    , .perf_cycles(perf_a)
`endif
  );

  matmul_pe_scheduler #(.n(3), .m(4)) u_b (
    .clk(clk), .rst(rst), .start(start_b), .pe_en(pe_en_b), .cmp_valid(cmp_b),
    .job_valid(job_valid_b), .job_pe(job_pe_b), .job_i(job_i_b), .job_j(job_j_b),
    .busy(busy_b), .done(done_b), .err_spurious(err_b)
`ifdef SCHED_PERF_CNT_EN
    , .perf_cycles(perf_b)
`endif
  );

  int pass_cnt = 0;
  int total_cnt = 0;

  longint exp_job_a[$];
  longint exp_job_b[$];
  int     exp_done_a[$];
  int     exp_done_b[$];

  task automatic check(input string name, input longint act, input longint exp);
    total_cnt++;
    if (act == exp) pass_cnt++;
    else $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
  endtask

  // job encoding: cycle*1e6 + pe*1e4 + i*100 + j
  function automatic longint enc(input int c, input int p, input int i, input int j);
    return longint'(c) * 1000000 + longint'(p) * 10000 + longint'(i) * 100 + longint'(j);
  endfunction

  // PE models: complete lat cycles after issue (auto) or manual pulses
  logic       auto_a, auto_b;
  int         lat_a, lat_b;
  logic [3:0] acmp_a, acmp_b, mcmp_a, mcmp_b;
  int         cnt_a[4] = '{default: 0};
  int         cnt_b[4] = '{default: 0};
  assign cmp_a = auto_a ? acmp_a : mcmp_a;
  assign cmp_b = auto_b ? acmp_b : mcmp_b;

  initial begin
    acmp_a = '0;
    acmp_b = '0;
    forever begin
      @(negedge clk);
      for (int p = 0; p < 4; p++) begin
        acmp_a[p] = 1'b0;
        acmp_b[p] = 1'b0;
        if (cnt_a[p] > 0) begin
          cnt_a[p]--;
          if (cnt_a[p] == 0) acmp_a[p] = 1'b1;
        end
        if (cnt_b[p] > 0) begin
          cnt_b[p]--;
          if (cnt_b[p] == 0) acmp_b[p] = 1'b1;
        end
      end
      if (auto_a && job_valid_a) cnt_a[int'(job_pe_a)] = lat_a;
      if (auto_b && job_valid_b) cnt_b[int'(job_pe_b)] = lat_b;
    end
  end

  // Scoreboard monitor
  initial begin
    forever begin
      @(negedge clk);
      if (job_valid_a) begin
        if (exp_job_a.size() == 0)
          check("job_a_unexpected", enc(cyc, int'(job_pe_a), int'(job_i_a), int'(job_j_a)), -1);
        else
          check("job_a", enc(cyc, int'(job_pe_a), int'(job_i_a), int'(job_j_a)), exp_job_a.pop_front());
      end
      if (done_a) begin
        if (exp_done_a.size() == 0) check("done_a_unexpected", cyc, -1);
        else check("done_a_cycle", cyc, exp_done_a.pop_front());
      end
      if (job_valid_b) begin
        if (exp_job_b.size() == 0)
          check("job_b_unexpected", enc(cyc, int'(job_pe_b), int'(job_i_b), int'(job_j_b)), -1);
        else
          check("job_b", enc(cyc, int'(job_pe_b), int'(job_i_b), int'(job_j_b)), exp_job_b.pop_front());
      end
      if (done_b) begin
        if (exp_done_b.size() == 0) check("done_b_unexpected", cyc, -1);
        else check("done_b_cycle", cyc, exp_done_b.pop_front());
      end
    end
  end

  task automatic wait_empty_a(input int budget);
    int k = 0;
    while ((exp_job_a.size() + exp_done_a.size()) != 0 && k < budget) begin
      @(negedge clk);
      k++;
    end
    check("drain_a", exp_job_a.size() + exp_done_a.size(), 0);
  endtask

  task automatic wait_empty_b(input int budget);
    int k = 0;
    while ((exp_job_b.size() + exp_done_b.size()) != 0 && k < budget) begin
      @(negedge clk);
      k++;
    end
    check("drain_b", exp_job_b.size() + exp_done_b.size(), 0);
  endtask

  task automatic pulse_b(input int at, input logic [3:0] v);
    while (cyc < at) @(negedge clk);
    mcmp_b = v;
    @(negedge clk);
    mcmp_b = '0;
  endtask

  int s;
  int pe_a2[4] = '{0, 2, 0, 2};

  initial begin
    rst = 1'b1; start_a = 1'b0; start_b = 1'b0;
    pe_en_a = '0; pe_en_b = '0; mcmp_a = '0; mcmp_b = '0;
    auto_a = 1'b1; auto_b = 1'b1; lat_a = 1; lat_b = 1;
    repeat (3) @(negedge clk);
    check("reset_a_outputs", longint'({job_valid_a, busy_a, done_a, err_a, job_pe_a, job_i_a, job_j_a}), 0);
    check("reset_b_outputs", longint'({job_valid_b, busy_b, done_b, err_b, job_pe_b, job_i_b, job_j_b}), 0);
    rst = 1'b0;
    @(negedge clk);
    check("idle_b_busy", busy_b, 0);

    // A1: all PEs enabled, 3-cycle latency
    pe_en_a = 4'hF; lat_a = 3;
    s = cyc;
    for (int k = 0; k < 4; k++) exp_job_a.push_back(enc(s + 1 + k, k, k / 2, k % 2));
    exp_done_a.push_back(s + 8);
    start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    wait_empty_a(60);
    @(negedge clk);
    check("a1_busy_after", busy_a, 0);
`ifdef SCHED_PERF_CNT_EN
    check("a1_perf", perf_a, 7);
`endif

    // A2: PEs 0 and 2 enabled, 1-cycle latency, pointer wraps past disabled PEs
    pe_en_a = 4'b0101; lat_a = 1;
    @(negedge clk);
    s = cyc;
    for (int k = 0; k < 4; k++) exp_job_a.push_back(enc(s + 1 + k, pe_a2[k], k / 2, k % 2));
    exp_done_a.push_back(s + 6);
    start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    wait_empty_a(60);
    @(negedge clk);
    check("a2_busy_after", busy_a, 0);

    // B2: all busy, simultaneous completions, spurious completion on idle PE2
    auto_b = 1'b0; pe_en_b = 4'hF;
    @(negedge clk);
    s = cyc;
    exp_job_b.push_back(enc(s + 1, 0, 0, 0));
    exp_job_b.push_back(enc(s + 2, 1, 0, 1));
    exp_job_b.push_back(enc(s + 3, 2, 0, 2));
    exp_job_b.push_back(enc(s + 4, 3, 1, 0));
    exp_job_b.push_back(enc(s + 7, 1, 1, 1));
    exp_job_b.push_back(enc(s + 8, 3, 1, 2));
    exp_job_b.push_back(enc(s + 11, 0, 2, 0));
    exp_job_b.push_back(enc(s + 12, 1, 2, 1));
    exp_job_b.push_back(enc(s + 13, 2, 2, 2));
    exp_done_b.push_back(s + 17);
    start_b = 1'b1;
    @(negedge clk);
    start_b = 1'b0;
    pulse_b(s + 6, 4'b1010);
    pulse_b(s + 10, 4'b1111);
    pulse_b(s + 11, 4'b0100);
    check("b2_err_set", err_b, 1);
    pulse_b(s + 15, 4'b0011);
    pulse_b(s + 16, 4'b0100);
    wait_empty_b(40);
    @(negedge clk);
    check("b2_err_sticky", err_b, 1);
    check("b2_busy_after", busy_b, 0);

    // B3: reset in DRAIN with 3 jobs outstanding (rr_ptr starts at 3)
    @(negedge clk);
    s = cyc;
    exp_job_b.push_back(enc(s + 1, 3, 0, 0));
    exp_job_b.push_back(enc(s + 2, 0, 0, 1));
    exp_job_b.push_back(enc(s + 3, 1, 0, 2));
    exp_job_b.push_back(enc(s + 4, 2, 1, 0));
    exp_job_b.push_back(enc(s + 7, 3, 1, 1));
    exp_job_b.push_back(enc(s + 8, 0, 1, 2));
    exp_job_b.push_back(enc(s + 9, 1, 2, 0));
    exp_job_b.push_back(enc(s + 10, 2, 2, 1));
    exp_job_b.push_back(enc(s + 12, 0, 2, 2));
    start_b = 1'b1;
    @(negedge clk);
    start_b = 1'b0;
    check("b3_err_cleared", err_b, 0);
    pulse_b(s + 6, 4'b1111);
    pulse_b(s + 11, 4'b0001);
    pulse_b(s + 14, 4'b0001);
    check("b3_busy_in_drain", busy_b, 1);
    rst = 1'b1;
    @(negedge clk);
    check("b3_reset_outputs", longint'({job_valid_b, busy_b, done_b, err_b, job_pe_b, job_i_b, job_j_b}), 0);
    rst = 1'b0;
    repeat (5) @(negedge clk);
    check("b3_jobs_seen", exp_job_b.size(), 0);
    check("b3_busy_after", busy_b, 0);

    // B1: single enabled PE, 1-cycle latency; start while busy is ignored
    auto_b = 1'b1; lat_b = 1; pe_en_b = 4'b0001;
    @(negedge clk);
    s = cyc;
    for (int k = 0; k < 9; k++) exp_job_b.push_back(enc(s + 1 + 2 * k, 0, k / 3, k % 3));
    exp_done_b.push_back(s + 19);
    start_b = 1'b1;
    @(negedge clk);
    start_b = 1'b0;
    while (cyc < s + 6) @(negedge clk);
    start_b = 1'b1;
    @(negedge clk);
    start_b = 1'b0;
    wait_empty_b(80);
    repeat (3) @(negedge clk);
    check("b1_busy_after", busy_b, 0);
`ifdef SCHED_PERF_CNT_EN
    check("b1_perf_hold", perf_b, 18);
`endif

    check("final_queues", exp_job_a.size() + exp_job_b.size() + exp_done_a.size() + exp_done_b.size(), 0);
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
